// File: rtl/bp_table_pkg.sv
// Shared constants and default parameters for the branch-prediction table.
package bp_table_pkg;

  localparam int unsigned BP_MODE_BIMODAL = 0;
  localparam int unsigned BP_MODE_GSHARE  = 1;

  localparam int unsigned BP_DEF_ENTRIES  = 64;
  localparam int unsigned BP_DEF_TAG_W    = 8;
  localparam int unsigned BP_DEF_CTR_W    = 2;
  localparam int unsigned BP_DEF_HIST_W   = 6;
  localparam int unsigned BP_DEF_PERF_W   = 32;

  localparam int unsigned BP_PC_W         = 32;
  localparam int unsigned BP_TGT_W        = 30;

  // Sequential fall-through address; wraps modulo 2^32.
  function automatic logic [BP_PC_W-1:0] bp_pc_plus4(input logic [BP_PC_W-1:0] pc);
    return pc + BP_PC_W'(4);
  endfunction

endpackage

// File: rtl/bp_table_if.sv
// Lookup, training and performance-counter signals of the prediction table.
interface bp_table_if
  import bp_table_pkg::*;
#(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned PERF_W = 32
);

  logic [BP_PC_W-1:0] pc_i;
  logic               lookup_valid_i;
  logic               pred_taken_o;
  logic [BP_PC_W-1:0] pred_target_o;
  logic [IDX_W-1:0]   pred_idx_o;

  logic               upd_valid_i;
  logic [IDX_W-1:0]   upd_idx_i;
  logic [BP_PC_W-1:0] upd_pc_i;
  logic               upd_taken_i;
  logic [BP_PC_W-1:0] upd_target_i;
  logic               upd_mispredict_i;
  logic               clear_i;

  logic [PERF_W-1:0]  perf_lookups_o;
  logic [PERF_W-1:0]  perf_mispredicts_o;

  modport slave (
    input  pc_i, lookup_valid_i,
    input  upd_valid_i, upd_idx_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  upd_mispredict_i, clear_i,
    output pred_taken_o, pred_target_o, pred_idx_o,
    output perf_lookups_o, perf_mispredicts_o
  );

  modport master (
    output pc_i, lookup_valid_i,
    output upd_valid_i, upd_idx_i, upd_pc_i, upd_taken_i, upd_target_i,
    output upd_mispredict_i, clear_i,
    input  pred_taken_o, pred_target_o, pred_idx_o,
    input  perf_lookups_o, perf_mispredicts_o
  );

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state function of an up/down saturating direction counter.
module bp_sat_ctr #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  // Step toward the observed direction, holding at either end.
  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != CTR_MAX) ctr_o = ctr_i + CTR_W'(1);
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/bp_table.sv
// Tagged BTB with saturating direction counters, bimodal or gshare indexed,
// combinational lookup and ID-stage training.
module bp_table
  import bp_table_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_DEF_ENTRIES,
  parameter int unsigned TAG_W   = BP_DEF_TAG_W,
  parameter int unsigned CTR_W   = BP_DEF_CTR_W,
  parameter int unsigned MODE    = BP_MODE_BIMODAL,
  parameter int unsigned HIST_W  = BP_DEF_HIST_W,
  parameter int unsigned PERF_W  = BP_DEF_PERF_W
) (
  input  logic       clk,
  input  logic       rst,
  bp_table_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

  // Entry storage lives in flops so lookup can be combinational.
  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [CTR_W-1:0]    ctr_q [ENTRIES];
  logic [BP_TGT_W-1:0] tgt_q [ENTRIES];

  logic [HIST_W-1:0]   ghr_q, ghr_d;
  logic [PERF_W-1:0]   lookups_q, lookups_d;
  logic [PERF_W-1:0]   mispred_q, mispred_d;

  logic [IDX_W-1:0]    hist_idx;
  logic [IDX_W-1:0]    lk_idx;
  logic                lk_hit, lk_taken;
  logic [IDX_W-1:0]    ui;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic [CTR_W-1:0]    upd_ctr_sat;
  logic                ent_wr, ent_alloc, tgt_wr;
  logic [CTR_W-1:0]    ent_ctr_d;

  function automatic logic [IDX_W-1:0] idx_of(input logic [BP_PC_W-1:0] pc,
                                               input logic [IDX_W-1:0]   hist);
    return pc[IDX_W+1:2] ^ hist;
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [BP_PC_W-1:0] pc);
    return pc[IDX_W+TAG_W+1:IDX_W+2];
  endfunction

  // History only perturbs the index in gshare mode.
  assign hist_idx = (MODE == BP_MODE_GSHARE) ? IDX_W'(ghr_q) : '0;

  // Combinational lookup off the IF-stage PC.
  always_comb begin
    lk_idx   = idx_of(bus.pc_i, hist_idx);
    lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == tag_of(bus.pc_i));
    lk_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
  end

  assign bus.pred_taken_o  = lk_taken;
  assign bus.pred_idx_o    = lk_idx;
  assign bus.pred_target_o = lk_taken ? {tgt_q[lk_idx], 2'b00} : bp_pc_plus4(bus.pc_i);

  assign ui      = bus.upd_idx_i;
  assign upd_tag = tag_of(bus.upd_pc_i);
  assign upd_hit = valid_q[ui] && (tag_q[ui] == upd_tag);

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr_i (ctr_q[ui]),
    .inc_i (bus.upd_taken_i),
    .ctr_o (upd_ctr_sat)
  );

  // Decide what the resolved branch writes into its entry; clear suppresses it.
  always_comb begin
    ent_wr    = 1'b0;
    ent_alloc = 1'b0;
    tgt_wr    = 1'b0;
    ent_ctr_d = ctr_q[ui];
    if (bus.upd_valid_i && !bus.clear_i) begin
      if (upd_hit) begin
        ent_wr    = 1'b1;
        ent_ctr_d = upd_ctr_sat;
        tgt_wr    = bus.upd_taken_i;
      end else if (bus.upd_taken_i) begin
        ent_wr    = 1'b1;
        ent_alloc = 1'b1;
        ent_ctr_d = CTR_WEAK_T;
        tgt_wr    = 1'b1;
      end
    end
  end

  // Table state; reset clears everything so an interrupted write leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        ctr_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      if (bus.clear_i)    valid_q     <= '0;
      else if (ent_alloc) valid_q[ui] <= 1'b1;
      if (ent_wr)    ctr_q[ui] <= ent_ctr_d;
      if (ent_alloc) tag_q[ui] <= upd_tag;
      if (tgt_wr)    tgt_q[ui] <= bus.upd_target_i[BP_PC_W-1:2];
    end
  end

  // Non-speculative history and saturating performance counters.
  always_comb begin
    ghr_d     = ghr_q;
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (bus.clear_i)          ghr_d = '0;
    else if (bus.upd_valid_i) ghr_d = HIST_W'({ghr_q, bus.upd_taken_i});
    if (bus.lookup_valid_i && (lookups_q != '1)) lookups_d = lookups_q + PERF_W'(1);
    if (bus.upd_valid_i && bus.upd_mispredict_i && (mispred_q != '1))
      mispred_d = mispred_q + PERF_W'(1);
  end

  // History and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q     <= '0;
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign bus.perf_lookups_o     = lookups_q;
  assign bus.perf_mispredicts_o = mispred_q;

  // PC bits outside index/tag and target alignment bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{bus.pc_i, bus.upd_pc_i, bus.upd_target_i, ghr_q};

endmodule

// File: tb/tb_bp_table.sv
// Bench for bp_table: a bimodal instance (PERF_W=3) and a gshare instance
// (HIST_W=2) driven in lockstep against a behavioural table model.
module tb_bp_table;

  localparam int unsigned NE   = 64;
  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0110;
  localparam logic [31:0] PC_C = 32'h0040_0040;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_table_if #(.IDX_W(6), .PERF_W(3))  bus_b ();
  bp_table_if #(.IDX_W(6), .PERF_W(32)) bus_g ();

  bp_table #(.ENTRIES(64), .TAG_W(8), .CTR_W(2), .MODE(0), .HIST_W(6), .PERF_W(3))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  bp_table #(.ENTRIES(64), .TAG_W(8), .CTR_W(2), .MODE(1), .HIST_W(2), .PERF_W(32))
    dut_g (.clk(clk), .rst(rst), .bus(bus_g));

  // Reference model: index 0 = bimodal instance, 1 = gshare instance.
  bit              m_v  [2][NE];
  int unsigned     m_tg [2][NE];
  int unsigned     m_ct [2][NE];
  logic [31:0]     m_tt [2][NE];
  int unsigned     m_ghr[2];
  longint unsigned m_lk [2];
  longint unsigned m_mp [2];
  longint unsigned perf_max[2];

  bit          s_lv, s_uv, s_tk, s_mp, s_clr;
  logic [31:0] s_upc, s_tgt;
  int unsigned s_ui[2];

  logic        obs_b_tk, obs_g_tk;
  logic [31:0] obs_b_tgt, obs_g_lk;
  logic [5:0]  obs_g_ix;
  logic [2:0]  obs_b_mp;

  int unsigned n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned m_idx(input int d, input logic [31:0] pc);
    int unsigned base;
    base = (pc >> 2) % NE;
    return (d == 1) ? (base ^ m_ghr[d]) : base;
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] pc);
    return (pc >> 8) % 256;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < int'(NE); i++) begin
        m_v[d][i] = 1'b0; m_ct[d][i] = 0; m_tg[d][i] = 0; m_tt[d][i] = '0;
      end
      m_ghr[d] = 0; m_lk[d] = 0; m_mp[d] = 0;
    end
  endtask

  // Apply one clock edge of the stored inputs to the model.
  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      int unsigned i;
      bit hit;
      i   = s_ui[d];
      hit = m_v[d][i] && (m_tg[d][i] == m_tag(s_upc));
      if (s_lv && m_lk[d] < perf_max[d]) m_lk[d]++;
      if (s_uv && s_mp && m_mp[d] < perf_max[d]) m_mp[d]++;
      if (s_clr) begin
        for (int k = 0; k < int'(NE); k++) m_v[d][k] = 1'b0;
        m_ghr[d] = 0;
      end else if (s_uv) begin
        if (hit) begin
          if (s_tk) begin
            m_ct[d][i] = (m_ct[d][i] == 3) ? 3 : m_ct[d][i] + 1;
            m_tt[d][i] = s_tgt & 32'hFFFF_FFFC;
          end else begin
            m_ct[d][i] = (m_ct[d][i] == 0) ? 0 : m_ct[d][i] - 1;
          end
        end else if (s_tk) begin
          m_v[d][i]  = 1'b1;
          m_tg[d][i] = m_tag(s_upc);
          m_ct[d][i] = 2;
          m_tt[d][i] = s_tgt & 32'hFFFF_FFFC;
        end
        if (d == 1) m_ghr[d] = ((m_ghr[d] << 1) | 32'(s_tk)) % 4;
      end
    end
  endtask

  task automatic drive(input logic [31:0] pc, input bit lv, input bit uv, input logic [31:0] upc,
                       input bit tk, input logic [31:0] tgt, input bit mp, input bit clr);
    s_lv = lv; s_uv = uv; s_upc = upc; s_tk = tk; s_tgt = tgt; s_mp = mp; s_clr = clr;
    s_ui[0] = m_idx(0, upc);
    s_ui[1] = m_idx(1, upc);
    bus_b.pc_i = pc; bus_b.lookup_valid_i = lv; bus_b.upd_valid_i = uv;
    bus_b.upd_idx_i = 6'(s_ui[0]); bus_b.upd_pc_i = upc; bus_b.upd_taken_i = tk;
    bus_b.upd_target_i = tgt; bus_b.upd_mispredict_i = mp; bus_b.clear_i = clr;
    bus_g.pc_i = pc; bus_g.lookup_valid_i = lv; bus_g.upd_valid_i = uv;
    bus_g.upd_idx_i = 6'(s_ui[1]); bus_g.upd_pc_i = upc; bus_g.upd_taken_i = tk;
    bus_g.upd_target_i = tgt; bus_g.upd_mispredict_i = mp; bus_g.clear_i = clr;
  endtask

  // Compare every output of both instances against the model's current state.
  task automatic check_outputs(input logic [31:0] pc);
    bit          e_tk [2];
    logic [31:0] e_tg [2];
    int unsigned e_ix [2];
    for (int d = 0; d < 2; d++) begin
      int unsigned i;
      i       = m_idx(d, pc);
      e_ix[d] = i;
      e_tk[d] = m_v[d][i] && (m_tg[d][i] == m_tag(pc)) && (m_ct[d][i] >= 2);
      e_tg[d] = e_tk[d] ? m_tt[d][i] : pc + 32'd4;
    end
    obs_b_tk = bus_b.pred_taken_o;  obs_b_tgt = bus_b.pred_target_o;
    obs_g_tk = bus_g.pred_taken_o;  obs_g_ix  = bus_g.pred_idx_o;
    obs_g_lk = bus_g.perf_lookups_o; obs_b_mp = bus_b.perf_mispredicts_o;
    check("b_taken",  32'(bus_b.pred_taken_o), 32'(e_tk[0]));
    check("b_target", bus_b.pred_target_o, e_tg[0]);
    check("b_idx",    32'(bus_b.pred_idx_o), e_ix[0]);
    check("b_perf_lk", 32'(bus_b.perf_lookups_o), 32'(m_lk[0]));
    check("b_perf_mp", 32'(bus_b.perf_mispredicts_o), 32'(m_mp[0]));
    check("g_taken",  32'(bus_g.pred_taken_o), 32'(e_tk[1]));
    check("g_target", bus_g.pred_target_o, e_tg[1]);
    check("g_idx",    32'(bus_g.pred_idx_o), e_ix[1]);
    check("g_perf_lk", bus_g.perf_lookups_o, 32'(m_lk[1]));
    check("g_perf_mp", bus_g.perf_mispredicts_o, 32'(m_mp[1]));
  endtask

  task automatic step(input logic [31:0] pc, input bit lv, input bit uv, input logic [31:0] upc,
                      input bit tk, input logic [31:0] tgt, input bit mp, input bit clr);
    @(negedge clk);
    drive(pc, lv, uv, upc, tk, tgt, mp, clr);
    #1;
    check_outputs(pc);
    @(posedge clk);
    m_edge();
  endtask

  task automatic look(input logic [31:0] pc);
    step(pc, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mp);
    step(pc, 1'b0, 1'b1, pc, tk, tgt, mp, 1'b0);
  endtask

  task automatic clr();
    step(PC_A, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    perf_max[0] = 64'd7; perf_max[1] = 64'hFFFF_FFFF;
    rst = 1'b1;
    drive(PC_A, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    m_reset();
    #2 rst = 1'b0;
    #10;
    check("rst_b_taken",  32'(bus_b.pred_taken_o), 32'd0);
    check("rst_b_target", bus_b.pred_target_o, 32'h0040_0014);
    check("rst_g_target", bus_g.pred_target_o, 32'h0040_0014);
    check("rst_b_perf_lk", 32'(bus_b.perf_lookups_o), 32'd0);
    check("rst_g_perf_mp", bus_g.perf_mispredicts_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    look(PC_A); look(PC_A); look(PC_A); look(PC_A);
    check("cold_taken", 32'(obs_b_tk), 32'd0);
    check("cold_target", obs_b_tgt, 32'h0040_0014);
    check("lookup_count", obs_g_lk, 32'd3);

    upd(PC_A, 1'b1, 32'h0040_0100, 1'b1);
    look(PC_A);
    check("alloc_taken", 32'(obs_b_tk), 32'd1);
    check("alloc_target", obs_b_tgt, 32'h0040_0100);

    upd(PC_A, 1'b0, 32'd0, 1'b1);
    upd(PC_A, 1'b0, 32'd0, 1'b0);
    look(PC_A);
    check("ctr_down_nt", 32'(obs_b_tk), 32'd0);

    for (int k = 0; k < 5; k++) upd(PC_A, 1'b1, 32'h0040_0100, 1'b0);
    upd(PC_A, 1'b0, 32'd0, 1'b0);
    look(PC_A);
    check("ctr_sat_taken", 32'(obs_b_tk), 32'd1);

    look(PC_B);
    check("alias_miss", 32'(obs_b_tk), 32'd0);
    upd(PC_B, 1'b1, 32'h0040_0200, 1'b1);
    look(PC_A);
    check("alias_evict", 32'(obs_b_tk), 32'd0);
    look(PC_B);
    check("alias_target", obs_b_tgt, 32'h0040_0200);

    clr();
    upd(PC_A, 1'b1, 32'h0040_0100, 1'b0);
    upd(PC_A, 1'b0, 32'd0, 1'b0);
    look(PC_A);
    check("gshare_idx", 32'(obs_g_ix), 32'd6);

    clr();
    step(PC_A, 1'b1, 1'b1, PC_A, 1'b1, 32'h0040_0300, 1'b0, 1'b0);
    check("same_cycle_old", 32'(obs_b_tk), 32'd0);
    look(PC_A);
    check("after_update", obs_b_tgt, 32'h0040_0300);

    step(PC_A, 1'b0, 1'b1, PC_A, 1'b1, 32'h0040_0300, 1'b0, 1'b1);
    look(PC_A);
    check("clear_wins", 32'(obs_b_tk), 32'd0);

    for (int k = 0; k < 9; k++) upd(PC_C, 1'b0, 32'd0, 1'b1);
    step(PC_A, 1'b0, 1'b0, PC_A, 1'b1, 32'd0, 1'b1, 1'b0);
    look(PC_A);
    check("mp_saturate", 32'(obs_b_mp), 32'd7);

    look(32'hFFFF_FFFC);
    check("pc_wrap", obs_b_tgt, 32'd0);

    // Reset asserted while an allocating update is presented.
    @(negedge clk);
    drive(PC_C, 1'b1, 1'b1, PC_C, 1'b1, 32'h0040_0400, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("midrst_b_perf_lk", 32'(bus_b.perf_lookups_o), 32'd0);
    check("midrst_g_perf_mp", bus_g.perf_mispredicts_o, 32'd0);
    check("midrst_target", bus_b.pred_target_o, 32'h0040_0044);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(PC_C, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    look(PC_C);
    check("midrst_no_entry", 32'(obs_b_tk), 32'd0);

    // Random traffic over a small PC pool so hits, aliases and saturation recur.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, upc, tgt;
      pc  = 32'h0040_0000 + 32'($urandom_range(0, 15) << 2) +
            (($urandom_range(0, 1) == 1) ? 32'(NE << 2) : 32'd0);
      upc = 32'h0040_0000 + 32'($urandom_range(0, 15) << 2) +
            (($urandom_range(0, 1) == 1) ? 32'(NE << 2) : 32'd0);
      tgt = $urandom;
      step(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), upc,
           1'($urandom_range(0, 1)), tgt, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
